// File: rtl/pmod_i2s2_pkg.sv
// ============================================================================
// pmod_i2s2_pkg
// ----------------------------------------------------------------------------
// Definitions shared by the Pmod I2S2 transmitter and receiver.
//   DEFAULT_SAMPLE_WIDTH : bits per channel sample, MSB first
//   DEFAULT_SLOT_WIDTH   : sclk periods per lrck channel slot
//   rx_state_t           : receiver framing state
//   sample_t             : one signed 24-bit audio sample
//   cnt_width()          : counter width able to hold 0..max_val
// ============================================================================
package pmod_i2s2_pkg;

    localparam int DEFAULT_SAMPLE_WIDTH = 24;
    localparam int DEFAULT_SLOT_WIDTH   = 32;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD
    } rx_state_t;

    typedef logic signed [23:0] sample_t;

    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pmod_i2s2_rx_sync_edge_det.sv
// ============================================================================
// sync_edge_det
// ----------------------------------------------------------------------------
// Brings an asynchronous strobe and its companion data lines into the clk_in
// domain. Every line passes through the same 2-FF synchroniser, so the data
// lines stay aligned with the strobe. A third register on the synchronised
// strobe provides rising-edge detection.
//
// Ports:
//   clk_in   : system clock
//   rst_in   : asynchronous active-low reset, clears every stage
//   edge_in  : asynchronous strobe (e.g. sclk)
//   data_in  : asynchronous lines sampled relative to the strobe
//   data_out : synchronised data_in, aligned with rise_out
//   rise_out : high for one cycle when the synchronised strobe rises
// ============================================================================
module sync_edge_det #(
    parameter int WIDTH = 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             edge_in,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             rise_out
);

    logic [WIDTH-1:0] data_meta;
    logic [WIDTH-1:0] data_sync;
    logic             edge_meta;
    logic             edge_sync;
    logic             edge_prev;

    // Two flops per line. The strobe and the data travel through identical
    // stages so that a data bit seen with a detected rise is the bit that was
    // on the pin at that strobe edge.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            data_meta <= '0;
            data_sync <= '0;
            edge_meta <= 1'b0;
            edge_sync <= 1'b0;
            edge_prev <= 1'b0;
        end else begin
            data_meta <= data_in;
            data_sync <= data_meta;
            edge_meta <= edge_in;
            edge_sync <= edge_meta;
            edge_prev <= edge_sync;
        end
    end

    assign data_out = data_sync;
    assign rise_out = edge_sync & ~edge_prev;

endmodule

// File: rtl/pmod_i2s2_rx.sv
// ============================================================================
// pmod_i2s2_rx
// ----------------------------------------------------------------------------
// I2S receiver for the Pmod I2S2 ADC path. sclk is treated as a sampled
// signal in the clk_in domain, never as a clock. Each lrck slot carries one
// 24-bit two's-complement sample, MSB first, after the standard 1-bit I2S
// delay. A left+right pair is presented together with a one-cycle valid.
//
// Ports:
//   clk_in        : system clock
//   rst_in        : asynchronous active-low reset
//   sclk_in       : I2S bit clock (high/low phases >= 4 clk_in cycles)
//   lrck_in       : I2S word select, 0 = left, 1 = right
//   sdata_in      : ADC serial data
//   left_out      : last complete left sample
//   right_out     : last complete right sample
//   valid_out     : one-cycle pulse when left_out/right_out update
//   frame_err_out : one-cycle pulse on a truncated or overlong slot
//   err_count_out : saturating count of framing errors
//                   (only when PMOD_I2S2_RX_ERR_COUNT_EN is defined)
//
// Optional build macro: PMOD_I2S2_RX_ERR_COUNT_EN
// ============================================================================
module pmod_i2s2_rx
    import pmod_i2s2_pkg::*;
#(
    parameter int SAMPLE_WIDTH = DEFAULT_SAMPLE_WIDTH,
    parameter int SLOT_WIDTH   = DEFAULT_SLOT_WIDTH
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    sclk_in,
    input  logic                    lrck_in,
    input  logic                    sdata_in,
    output logic [SAMPLE_WIDTH-1:0] left_out,
    output logic [SAMPLE_WIDTH-1:0] right_out,
    output logic                    valid_out,
    output logic                    frame_err_out
`ifdef PMOD_I2S2_RX_ERR_COUNT_EN
    ,
    output logic [15:0]             err_count_out
`endif
);

    localparam int BIT_W  = cnt_width(SAMPLE_WIDTH);
    localparam int SLOT_W = cnt_width(SLOT_WIDTH);

    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(SAMPLE_WIDTH - 1);
    localparam logic [SLOT_W-1:0] SLOT_MAX = SLOT_W'(SLOT_WIDTH);

    logic [1:0]              line_sync;
    logic                    sclk_rise;
    logic                    lrck_s;
    logic                    sdata_s;
    logic                    boundary;
    logic [SAMPLE_WIDTH-1:0] shift_next;

    rx_state_t               state;
    logic                    channel;
    logic                    lrck_last;
    logic                    left_held;
    logic [BIT_W-1:0]        bitcnt;
    logic [SLOT_W-1:0]       slot_cnt;
    logic [SAMPLE_WIDTH-1:0] shreg;
    logic [SAMPLE_WIDTH-1:0] hold_left;

    // One synchroniser instance for the whole bus keeps lrck and sdata in
    // lock-step with the sclk rise they belong to.
    sync_edge_det #(
        .WIDTH (2)
    ) u_sync (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .edge_in  (sclk_in),
        .data_in  ({sdata_in, lrck_in}),
        .data_out (line_sync),
        .rise_out (sclk_rise)
    );

    assign lrck_s     = line_sync[0];
    assign sdata_s    = line_sync[1];
    assign boundary   = (lrck_s != lrck_last);
    assign shift_next = {shreg[SAMPLE_WIDTH-2:0], sdata_s};

    // Framing FSM. Everything advances only on a detected sclk rise.
    // A boundary rise carries the I2S delay bit, so its data is dropped and
    // the slot counters restart from zero. slot_cnt counts the non-boundary
    // rises of the current slot; one more than SLOT_WIDTH means lrck stalled.
    // A left sample is only kept while it can still be paired: any framing
    // error or return to IDLE forgets it, so a right sample alone never
    // produces valid_out.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state         <= IDLE;
            channel       <= 1'b0;
            lrck_last     <= 1'b0;
            left_held     <= 1'b0;
            bitcnt        <= '0;
            slot_cnt      <= '0;
            shreg         <= '0;
            hold_left     <= '0;
            left_out      <= '0;
            right_out     <= '0;
            valid_out     <= 1'b0;
            frame_err_out <= 1'b0;
        end else begin
            valid_out     <= 1'b0;
            frame_err_out <= 1'b0;
            if (sclk_rise) begin
                lrck_last <= lrck_s;
                case (state)
                    IDLE: begin
                        // Only a boundary into left starts capture, so
                        // every frame begins with a left slot.
                        left_held <= 1'b0;
                        if (boundary && !lrck_s) begin
                            state    <= SHIFT;
                            channel  <= 1'b0;
                            bitcnt   <= '0;
                            slot_cnt <= '0;
                        end
                    end

                    SHIFT: begin
                        if (boundary) begin
                            // Slot ended before the LSB arrived.
                            frame_err_out <= 1'b1;
                            left_held     <= 1'b0;
                            bitcnt        <= '0;
                            slot_cnt      <= '0;
                            channel       <= 1'b0;
                            state         <= lrck_s ? IDLE : SHIFT;
                        end else if (slot_cnt == SLOT_MAX) begin
                            frame_err_out <= 1'b1;
                            left_held     <= 1'b0;
                            state         <= IDLE;
                        end else begin
                            slot_cnt <= slot_cnt + 1'b1;
                            shreg    <= shift_next;
                            bitcnt   <= bitcnt + 1'b1;
                            if (bitcnt == BIT_LAST) begin
                                state <= HOLD;
                                if (!channel) begin
                                    hold_left <= shift_next;
                                    left_held <= 1'b1;
                                end else begin
                                    left_held <= 1'b0;
                                    if (left_held) begin
                                        left_out  <= hold_left;
                                        right_out <= shift_next;
                                        valid_out <= 1'b1;
                                    end
                                end
                            end
                        end
                    end

                    HOLD: begin
                        if (boundary) begin
                            state    <= SHIFT;
                            channel  <= lrck_s;
                            bitcnt   <= '0;
                            slot_cnt <= '0;
                        end else if (slot_cnt == SLOT_MAX) begin
                            frame_err_out <= 1'b1;
                            left_held     <= 1'b0;
                            state         <= IDLE;
                        end else begin
                            slot_cnt <= slot_cnt + 1'b1;
                        end
                    end

                    default: begin
                        state     <= IDLE;
                        left_held <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef PMOD_I2S2_RX_ERR_COUNT_EN
    // Counts framing-error pulses one cycle after they appear; holds at the
    // top value instead of wrapping so a long-running error burst stays
    // visible.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            err_count_out <= '0;
        end else if (frame_err_out && (err_count_out != 16'hFFFF)) begin
            err_count_out <= err_count_out + 16'd1;
        end
    end
`endif

endmodule
